// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings for the hazard controller (ResultSrc and forward-select)
package hazard_pkg;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } res_src_e;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: forward-select for one EX operand from the M/W destination scoreboard
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              we_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              we_w,
    output logic [1:0]        fwd
);

    logic hit_m;
    logic hit_w;

    // M holds the younger result so it wins over W; x0 never forwards
    always_comb begin
        hit_m = we_m && rd_m != '0 && rd_m == rs;
        hit_w = we_w && rd_w != '0 && rd_w == rs;
        fwd   = hit_m ? FWD_M : hit_w ? FWD_W : FWD_RF;
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: stall/flush/forward control for the 5-stage core; HAZ_PERF_CNT_EN adds stall/flush perf counters
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic              RegWriteE,
    input  logic [1:0]        ResultSrcE,
    input  logic              PCSrcE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt
);

    logic [REG_AW-1:0] rd_m;
    logic [REG_AW-1:0] rd_w;
    logic              we_m;
    logic              we_w;
    logic              lw_stall;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;

    // M/W destination scoreboard; those stages never stall so it shifts every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_m <= '0;
            we_m <= 1'b0;
            rd_w <= '0;
            we_w <= 1'b0;
        end else begin
            rd_m <= RdE;
            we_m <= RegWriteE;
            rd_w <= rd_m;
            we_w <= we_m;
        end
    end

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs   (Rs1E),
        .rd_m (rd_m),
        .we_m (we_m),
        .rd_w (rd_w),
        .we_w (we_w),
        .fwd  (fwd_a)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs   (Rs2E),
        .rd_m (rd_m),
        .we_m (we_m),
        .rd_w (rd_w),
        .we_w (we_w),
        .fwd  (fwd_b)
    );

    // load-use detection and control outputs; reset forces both buffers to flush and blocks forwarding
    always_comb begin
        lw_stall  = ResultSrcE == RES_MEM && RdE != '0 && (RdE == Rs1D || RdE == Rs2D);
        StallF    = !rst && lw_stall;
        StallD    = !rst && lw_stall;
        FlushD    = rst || PCSrcE;
        FlushE    = rst || PCSrcE || lw_stall;
        ForwardAE = rst ? FWD_RF : fwd_a;
        ForwardBE = rst ? FWD_RF : fwd_b;
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // saturating event counters for load-use stalls and control flushes
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (lw_stall && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (PCSrcE && !(&flush_cnt))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign StallCnt = stall_cnt;
    assign FlushCnt = flush_cnt;
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: directed bench with a pipeline-history model checked every cycle
module tb_hazard_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
    logic        RegWriteE;
    logic [1:0]  ResultSrcE;
    logic        PCSrcE;
    logic        StallF, StallD, FlushD, FlushE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] StallCnt, FlushCnt;

    int vectors = 0;
    int miscompares = 0;
    bit started = 1'b0;

    // model state: older instructions as a two-deep list, [0] = just left EX (in M), [1] = in W
    int     hist_rd [2];
    bit     hist_we [2];
    longint m_stall_cnt, m_flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl_unit dut (
        .clk        (clk),
        .rst        (rst),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .RegWriteE  (RegWriteE),
        .ResultSrcE (ResultSrcE),
        .PCSrcE     (PCSrcE),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .StallCnt   (StallCnt),
        .FlushCnt   (FlushCnt)
    );

    function automatic bit m_lw();
        return ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (rst) return 2'b00;
        for (int k = 0; k < 2; k++)
            if (hist_we[k] && hist_rd[k] != 0 && hist_rd[k] == int'(rs))
                return k == 0 ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    // advance the model one cycle
    always @(posedge clk) begin
        if (rst) begin
            hist_rd = '{0, 0};
            hist_we = '{0, 0};
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end else begin
`ifdef HAZ_PERF_CNT_EN
            if (m_lw() && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
            if (PCSrcE && m_flush_cnt < 64'hFFFF_FFFF) m_flush_cnt++;
`endif
            hist_rd[1] = hist_rd[0];
            hist_we[1] = hist_we[0];
            hist_rd[0] = int'(RdE);
            hist_we[0] = RegWriteE;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            chk("model_StallF", 32'(StallF), 32'(!rst && m_lw()));
            chk("model_StallD", 32'(StallD), 32'(!rst && m_lw()));
            chk("model_FlushD", 32'(FlushD), 32'(rst || PCSrcE));
            chk("model_FlushE", 32'(FlushE), 32'(rst || PCSrcE || m_lw()));
            chk("model_ForwardAE", 32'(ForwardAE), 32'(m_fwd(Rs1E)));
            chk("model_ForwardBE", 32'(ForwardBE), 32'(m_fwd(Rs2E)));
            chk("model_StallCnt", StallCnt, 32'(m_stall_cnt));
            chk("model_FlushCnt", FlushCnt, 32'(m_flush_cnt));
        end
    end

    task automatic set(input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, input logic we,
                       input logic [1:0] rsrc, input logic pcs);
        Rs1D = rs1d; Rs2D = rs2d; Rs1E = rs1e; Rs2E = rs2e; RdE = rde;
        RegWriteE = we; ResultSrcE = rsrc; PCSrcE = pcs;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        started = 1'b1;
        // lw x5 in EX during reset: flush both, no stall, no forward
        set(5, 0, 5, 5, 5, 1, 2'b01, 0);
        chk("rst_StallF", 32'(StallF), 0);
        chk("rst_StallD", 32'(StallD), 0);
        chk("rst_FlushD", 32'(FlushD), 1);
        chk("rst_FlushE", 32'(FlushE), 1);
        chk("rst_ForwardAE", 32'(ForwardAE), 0);
        tick();
        tick();
        rst = 1'b0;
        // first cycle after release: scoreboard empty
        set(0, 0, 5, 5, 0, 0, 2'b00, 0);
        chk("post_rst_ForwardAE", 32'(ForwardAE), 0);
        chk("post_rst_ForwardBE", 32'(ForwardBE), 0);
        chk("post_rst_FlushD", 32'(FlushD), 0);
        chk("post_rst_StallCnt", StallCnt, 0);
        tick();
        // add x5 ; add x6,x5,x1
        set(5, 1, 1, 2, 5, 1, 2'b00, 0);
        chk("alu_no_stall", 32'(StallF), 0);
        tick();
        set(0, 0, 5, 1, 6, 1, 2'b00, 0);
        chk("t1_ForwardAE", 32'(ForwardAE), 2'b10);
        chk("t1_ForwardBE", 32'(ForwardBE), 2'b00);
        tick();
        // add x5 ; nop ; sub x7,x1,x5
        set(0, 0, 1, 2, 5, 1, 2'b00, 0);
        tick();
        set(0, 0, 0, 0, 0, 0, 2'b00, 0);
        tick();
        set(0, 0, 1, 5, 7, 1, 2'b00, 0);
        chk("t2_ForwardBE", 32'(ForwardBE), 2'b01);
        chk("t2_ForwardAE", 32'(ForwardAE), 2'b00);
        tick();
        // x5 written by both M and W: M wins
        set(0, 0, 0, 0, 5, 1, 2'b00, 0);
        tick();
        set(0, 0, 0, 0, 5, 1, 2'b00, 0);
        tick();
        set(0, 0, 5, 5, 0, 0, 2'b00, 0);
        chk("prio_ForwardAE", 32'(ForwardAE), 2'b10);
        tick();
        // lw x5 in EX, and x8,x5,x2 in ID
        set(5, 2, 0, 0, 5, 1, 2'b01, 0);
        chk("t3_StallF", 32'(StallF), 1);
        chk("t3_StallD", 32'(StallD), 1);
        chk("t3_FlushE", 32'(FlushE), 1);
        chk("t3_FlushD", 32'(FlushD), 0);
        tick();
        set(5, 2, 0, 0, 0, 0, 2'b00, 0);
        chk("t3_stall_one_cycle", 32'(StallF), 0);
        chk("t3_FlushE_clear", 32'(FlushE), 0);
        tick();
        set(0, 0, 5, 2, 8, 1, 2'b00, 0);
        chk("t3_ForwardAE", 32'(ForwardAE), 2'b01);
        tick();
        // load matching Rs2D stalls; non-matching load and PC+4 match do not
        set(3, 9, 0, 0, 9, 1, 2'b01, 0);
        chk("lw_rs2_stall", 32'(StallD), 1);
        tick();
        set(3, 4, 0, 0, 9, 1, 2'b01, 0);
        chk("lw_nomatch", 32'(StallF), 0);
        tick();
        set(9, 4, 0, 0, 9, 1, 2'b10, 0);
        chk("pc4_no_stall", 32'(StallF), 0);
        tick();
        // taken branch for one cycle
        set(0, 0, 0, 0, 0, 0, 2'b00, 1);
        chk("t4_FlushD", 32'(FlushD), 1);
        chk("t4_FlushE", 32'(FlushE), 1);
        chk("t4_StallF", 32'(StallF), 0);
        tick();
        set(0, 0, 0, 0, 0, 0, 2'b00, 0);
        chk("t4_FlushD_off", 32'(FlushD), 0);
        chk("t4_FlushE_off", 32'(FlushE), 0);
        tick();
        // load-use and branch together
        set(5, 0, 0, 0, 5, 1, 2'b01, 1);
        chk("both_FlushD", 32'(FlushD), 1);
        chk("both_StallF", 32'(StallF), 1);
        chk("both_FlushE", 32'(FlushE), 1);
        tick();
        // writes to x0 never forward; lw x0 never stalls
        set(0, 0, 0, 0, 0, 1, 2'b00, 0);
        tick();
        set(0, 0, 0, 0, 0, 1, 2'b00, 0);
        tick();
        set(0, 0, 0, 0, 0, 1, 2'b01, 0);
        chk("t5_ForwardAE_x0", 32'(ForwardAE), 0);
        chk("t5_lw_x0_no_stall", 32'(StallF), 0);
        tick();
        // destination without write enable never forwards
        set(0, 0, 0, 0, 4, 0, 2'b00, 0);
        tick();
        set(0, 0, 4, 4, 0, 0, 2'b00, 0);
        chk("no_we_ForwardAE", 32'(ForwardAE), 0);
        tick();
        // mixed directed table exercised only through the model
        for (int i = 0; i < 40; i++) begin
            set(5'(i % 4), 5'((i * 3) % 5), 5'((i * 7) % 4), 5'((i + 1) % 3),
                5'((i * 5) % 4), 1'(i % 3 != 0), 2'(i % 3), 1'(i % 7 == 0));
            tick();
        end
        // reset while lw in EX, then three load-use stalls
        rst = 1'b1;
        set(5, 0, 0, 0, 5, 1, 2'b01, 0);
        chk("t6_rst_StallF", 32'(StallF), 0);
        chk("t6_rst_FlushE", 32'(FlushE), 1);
        tick();
        rst = 1'b0;
        set(0, 0, 5, 0, 0, 0, 2'b00, 0);
        chk("t6_empty_ForwardAE", 32'(ForwardAE), 0);
        chk("t6_StallCnt0", StallCnt, 0);
        chk("t6_FlushCnt0", FlushCnt, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set(6, 0, 0, 0, 6, 1, 2'b01, 0);
            tick();
        end
        set(0, 0, 0, 0, 0, 0, 2'b00, 0);
`ifdef HAZ_PERF_CNT_EN
        chk("t6_StallCnt3", StallCnt, 3);
`else
        chk("t6_StallCnt_tied", StallCnt, 0);
`endif
        tick();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
